// File: rtl/jtkcpu_shd.sv
// jtkcpu_shd: iterative multi-bit shifter/rotator for KONAMI-2 count-based shifts
module jtkcpu_shd(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        len,
  input  logic [15:0] din,
  input  logic [7:0]  cnt,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic        c_out,
  output logic        v_out,
  output logic        z_out,
  output logic        n_out
);
  localparam logic [0:0] IDLE = 1'b0, SHIFT = 1'b1;
  localparam logic [2:0] LSR = 3'd0, ASR = 3'd1, ASL = 3'd2, ROR = 3'd3, ROL = 3'd4;
  logic [0:0]  state;
  logic [2:0]  op_r;
  logic        len_r, c_r, v_r;
  logic [15:0] wr, nxt_w;
  logic [7:0]  left, eff, wmax;
  logic        msb, nmsb, right, fill, nxt_c, zero, vop;
  assign busy  = state == SHIFT;
  assign wmax  = len ? 8'd16 : 8'd8;
  // shifts saturate one past the width so the carry also drains to zero
  assign eff   = (op == LSR || op == ASL) ? (cnt > wmax ? wmax + 8'd1 : cnt) :
                 op == ASR ? (cnt > wmax ? wmax : cnt) :
                 (op == ROR || op == ROL) ? cnt : 8'd0;
  assign msb   = len_r ? wr[15] : wr[7];
  assign nmsb  = len_r ? wr[14] : wr[6];
  assign vop   = op_r == ASL || op_r == ROL;
  assign right = op_r == LSR || op_r == ASR || op_r == ROR;
  assign fill  = op_r == ASR ? msb : (op_r == ROR || op_r == ROL) ? c_r : 1'b0;
  assign nxt_w = right ? (len_r ? {fill, wr[15:1]} : {wr[15:8], fill, wr[7:1]})
                       : (len_r ? {wr[14:0], fill} : {wr[15:8], wr[6:0], fill});
  assign nxt_c = right ? wr[0] : msb;
  assign zero  = len_r ? wr == 16'd0 : wr[7:0] == 8'd0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      op_r  <= 3'd0;
      len_r <= 1'b0;
      wr    <= 16'd0;
      c_r   <= 1'b0;
      v_r   <= 1'b0;
      left  <= 8'd0;
      done  <= 1'b0;
      dout  <= 16'd0;
      c_out <= 1'b0;
      v_out <= 1'b0;
      z_out <= 1'b0;
      n_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cen) begin
        if (state == IDLE) begin
          if (start) begin
            op_r  <= op;
            len_r <= len;
            wr    <= din;
            c_r   <= cin;
            v_r   <= 1'b0;
            left  <= eff;
            state <= SHIFT;
          end
        end else if (left != 8'd0) begin
          wr   <= nxt_w;
          c_r  <= nxt_c;
          v_r  <= v_r | (vop & (msb ^ nmsb));
          left <= left - 8'd1;
        end else begin
          dout  <= wr;
          c_out <= c_r;
          v_out <= v_r;
          z_out <= zero;
          n_out <= msb;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_jtkcpu_shd.sv
// tb_jtkcpu_shd: scoreboard bench for the iterative shifter/rotator
module tb_jtkcpu_shd;
  logic clk = 1'b0, rst = 1'b0, cen = 1'b1, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic len = 1'b0, cin = 1'b0;
  logic [15:0] din = 16'd0;
  logic [7:0] cnt = 8'd0;
  logic busy, done, c_out, v_out, z_out, n_out;
  logic [15:0] dout;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [15:0] d;
    logic c, v, z, n;
    logic [8:0] lat;
  } exp_t;
  exp_t q[$];

  jtkcpu_shd dut(
    .clk(clk), .rst(rst), .cen(cen), .start(start), .op(op), .len(len),
    .din(din), .cnt(cnt), .cin(cin), .busy(busy), .done(done), .dout(dout),
    .c_out(c_out), .v_out(v_out), .z_out(z_out), .n_out(n_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic l, input logic [15:0] d,
                                 input logic [7:0] c, input logic ci);
    int w = l ? 16 : 8;
    int mask = l ? 32'hFFFF : 32'hFF;
    int mm = l ? 32'h8000 : 32'h80;
    int f = d & mask;
    int n;
    logic cy = ci, v = 1'b0, nb;
    exp_t e;
    case (o)
      3'd0, 3'd2: n = (c > w + 1) ? w + 1 : c;
      3'd1:       n = (c > w) ? w : c;
      3'd3, 3'd4: n = c;
      default:    n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      case (o)
        3'd0: begin cy = f[0]; f = f >> 1; end
        3'd1: begin cy = f[0]; f = (f >> 1) | (f & mm); end
        3'd2: begin nb = (f & mm) != 0; f = (f << 1) & mask; cy = nb; v |= nb ^ ((f & mm) != 0); end
        3'd3: begin nb = f[0]; f = (f >> 1) | (cy ? mm : 0); cy = nb; end
        default: begin nb = (f & mm) != 0; f = ((f << 1) & mask) | int'(cy); cy = nb; v |= nb ^ ((f & mm) != 0); end
      endcase
    end
    e.d = l ? f[15:0] : {d[15:8], f[7:0]};
    e.c = cy;
    e.v = v;
    e.z = f == 0;
    e.n = (f & mm) != 0;
    e.lat = 9'(n + 1);
    return e;
  endfunction

  task automatic run(input logic [2:0] o, input logic l, input logic [15:0] d, input logic [7:0] c,
                     input logic ci, input bit tog, input bit poke);
    exp_t e;
    int ncen = 0, k = 0;
    bit got = 0;
    q.push_back(model(o, l, d, c, ci));
    @(negedge clk);
    op = o; len = l; din = d; cnt = c; cin = ci; start = 1'b1; cen = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
    while (!got && k < 600) begin
      @(negedge clk);
      cen = tog ? ~cen : 1'b1;
      start = poke && k == 2;
      if (start) begin din = 16'h5A5A; cnt = 8'd3; op = 3'd0; cin = ~ci; end
      ncen += int'(cen);
      @(posedge clk); #1;
      k++;
      if (done) got = 1;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    e = q.pop_front();
    check("latency", ncen, e.lat);
    check("busy_fall", busy, 0);
    check("dout", dout, e.d);
    check("flags", {c_out, v_out, z_out, n_out}, {e.c, e.v, e.z, e.n});
    @(negedge clk);
    cen = tog ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    check("done_width", done, 0);
    check("dout_hold", dout, e.d);
    cen = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out", {done, dout, c_out, v_out, z_out, n_out}, 0);
    @(negedge clk) rst = 1'b1;
    run(3'd0, 1'b1, 16'h8001, 8'd1, 1'b0, 0, 0);
    run(3'd2, 1'b0, 16'h12C0, 8'd2, 1'b0, 0, 0);
    run(3'd1, 1'b1, 16'h8000, 8'd200, 1'b0, 0, 0);
    run(3'd4, 1'b0, 16'h0081, 8'd9, 1'b0, 0, 0);
    run(3'd3, 1'b1, 16'h0001, 8'd1, 1'b1, 0, 0);
    // abort a run with async reset after four steps
    @(negedge clk);
    op = 3'd0; len = 1'b1; din = 16'hFFFF; cnt = 8'd10; cin = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", {done, dout, c_out, v_out, z_out, n_out}, 0);
    @(negedge clk) rst = 1'b1;
    run(3'd0, 1'b1, 16'h0000, 8'd0, 1'b1, 0, 0);
    run(3'd2, 1'b1, 16'h4001, 8'd5, 1'b0, 0, 1);
    run(3'd6, 1'b1, 16'h8000, 8'd7, 1'b1, 0, 0);
    run(3'd4, 1'b1, 16'hB3C5, 8'd20, 1'b1, 1, 0);
    run(3'd0, 1'b0, 16'hABFF, 8'd255, 1'b1, 0, 0);
    run(3'd3, 1'b1, 16'h1234, 8'd255, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++)
      run(3'($urandom_range(0, 4)), 1'($urandom), 16'($urandom), 8'($urandom_range(0, 40)),
          1'($urandom), bit'(i % 2), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtkcpu_shd.md
# jtkcpu_shd

Iterative multi-bit shifter/rotator for the KONAMI-2 count-based shift instructions (LSRD, ASRD, ASLD, RORD, ROLD and byte variants with a count operand). The ALU cannot finish these in one cycle. The block sits beside the ALU as a start/busy responder, in the same way as the divider. The sequencer starts it with operand, count and carry, waits for `done`, then writes `dout` and the flags back to D/CC.

## Interface
Parameters: none.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `cen`  in  1  clock enable; all state advances only when high
- `start`  in  1  request; sampled when `cen` is high and the block is idle
- `op`  in  3  0 LSR, 1 ASR, 2 ASL/LSL, 3 ROR, 4 ROL; 5–7 reserved
- `len`  in  1  1 = 16-bit (D/W), 0 = 8-bit (low byte)
- `din`  in  16  operand
- `cnt`  in  8  shift count, unsigned
- `cin`  in  1  CC.C at start
- `busy`  out  1  operation in progress
- `done`  out  1  one-clock pulse when the result is valid
- `dout`  out  16  result, held until the next start
- `c_out`, `v_out`, `z_out`, `n_out`  out  1 each  flags, held with `dout`

## Operation
- States: IDLE, SHIFT.
- IDLE with `cen & start`:
  - Latch `op`, `len`, `din` and `cin` into a working register and carry.
  - Latch the effective count, clear sticky V, go to SHIFT, set `busy`.
- Effective count, where w = 16 or 8:
  - LSR, ASL: min(`cnt`, w+1).
  - ASR: min(`cnt`, w).
  - ROR, ROL: `cnt` unsaturated.
  - Reserved ops: 0.
- SHIFT, per `cen` cycle with remaining count > 0: one bit step on the w-bit field, then decrement the count.
  - LSR: C ← bit0, msb ← 0.
  - ASR: C ← bit0, msb kept.
  - ASL: C ← msb, bit0 ← 0.
  - ROR: 17/9-bit ring, msb ← C, C ← bit0.
  - ROL: 17/9-bit ring, bit0 ← C, C ← msb.
  - ASL and ROL: sticky V |= (old msb ^ new msb).
- SHIFT with count = 0 and `cen`:
  - Load `dout` from the working register.
  - Flags: C = working carry; V = sticky V for ASL/ROL, 0 otherwise; Z = (w-bit field == 0); N = field msb.
  - Pulse `done`, clear `busy`, go to IDLE.
- 8-bit mode: `dout[15:8]` = latched `din[15:8]`, untouched; flags use bits 7:0 only.
- Count 0: `dout` = `din`, C = `cin`, V = 0, Z/N from `din`.
- Reserved ops behave as count 0.
- `start` while busy is ignored; the latched operands do not change.
- `cen` low freezes the state, count and `done`. `done` asserts only on a `cen`-high edge and lasts exactly one `clk` cycle.

## Timing
- Reset (async, any time, including mid-operation): state IDLE, `busy`=0, `done`=0, `dout`=0, all flags 0, count 0.
- Latency: `busy` rises at the start edge. `done` and the results appear N+1 `cen` cycles later, where N is the effective count.
- `busy` falls on the same edge that `done` rises.
- A new `start` is accepted on the edge after `done`, or on any later one.
- Maximum latency is 256 `cen` cycles (ROR/ROL with `cnt`=255).
- Outputs are registered, with no combinational path from any input to any output.

## Test plan
- LSR, 16-bit, `din`=8001h, `cnt`=1, `cin`=0 → `dout`=4000h, C=1, Z=0, N=0, V=0; `done` 2 `cen` cycles after start.
- ASL, 8-bit, `din`=12C0h, `cnt`=2 → `dout`=1200h, C=1, V=1, Z=1, N=0; upper byte preserved.
- ASR, 16-bit, `din`=8000h, `cnt`=200 → saturates to 16 steps: `dout`=FFFFh, C=1, N=1; `done` 17 cycles after start.
- ROL, 8-bit, `din`=0081h, `cin`=0, `cnt`=9 → full ring: `dout`=0081h, C=0. ROR, 16-bit, `din`=0001h, `cnt`=1, `cin`=1 → `dout`=8000h, C=1, N=1.
- `cnt`=0, op LSR, `din`=0000h, `cin`=1 → `dout`=0000h, C=1, Z=1, V=0, `done` 1 cycle after start. Re-assert `start` while busy during a `cnt`=5 run → ignored, result unchanged.
- Drop `rst` mid-run (`cnt`=10, after 4 steps) → `busy`=0, `dout`=0, flags 0 immediately. Toggle `cen` at 50% during a run → latency counts `cen` cycles only, and `done` is one `clk` wide.
